// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: ALU op codes, forwarding selects,
// control-bundle bit positions and the mul/div sequencer types.
package mips_pkg;

    typedef enum logic [5:0] {
        ALU_NOP   = 6'd0,
        ALU_ADD   = 6'd1,
        ALU_ADDU  = 6'd2,
        ALU_SUB   = 6'd3,
        ALU_SUBU  = 6'd4,
        ALU_AND   = 6'd5,
        ALU_OR    = 6'd6,
        ALU_XOR   = 6'd7,
        ALU_NOR   = 6'd8,
        ALU_SLT   = 6'd9,
        ALU_SLTU  = 6'd10,
        ALU_SLL   = 6'd11,
        ALU_SRL   = 6'd12,
        ALU_SRA   = 6'd13,
        ALU_SLLV  = 6'd14,
        ALU_SRLV  = 6'd15,
        ALU_SRAV  = 6'd16,
        ALU_LUI   = 6'd17,
        ALU_MFHI  = 6'd18,
        ALU_MFLO  = 6'd19,
        ALU_MTHI  = 6'd20,
        ALU_MTLO  = 6'd21,
        ALU_MULT  = 6'd22,
        ALU_MULTU = 6'd23,
        ALU_DIV   = 6'd24,
        ALU_DIVU  = 6'd25
    } alu_op_e;

    localparam logic [1:0] FW_REG   = 2'b00;
    localparam logic [1:0] FW_MEMWB = 2'b01;
    localparam logic [1:0] FW_EXMEM = 2'b10;
    localparam logic [1:0] FW_RSVD  = 2'b11;

    localparam int CTRL_W        = 7;
    localparam int CTRL_MEM2REG  = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_SIGN     = 2;
    localparam int CTRL_WIDTH_HI = 1;
    localparam int CTRL_WIDTH_LO = 0;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_md_op(input alu_op_e op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic md_op_e to_md_op(input alu_op_e op);
        case (op)
            ALU_MULTU: return MD_MULTU;
            ALU_DIV:   return MD_DIV;
            ALU_DIVU:  return MD_DIVU;
            default:   return MD_MULT;
        endcase
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide on operand magnitudes; sign correction is applied
// in the FIX state, where done is high and hi/lo carry the final result.
module md_unit
    import mips_pkg::*;
#(
    parameter int NB_DATA         = 32,
    parameter int MD_BITS_PER_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  md_op_e             op,
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [NB_DATA-1:0] hi,
    output logic [NB_DATA-1:0] lo
);

    localparam int STEPS = NB_DATA / MD_BITS_PER_CYC;
    localparam int CW    = $clog2(STEPS);
    localparam logic [CW-1:0]      CNT_LAST = CW'(STEPS - 1);
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [NB_DATA-1:0] ZERO     = {NB_DATA{1'b0}};
    localparam logic [NB_DATA-1:0] ONES     = {NB_DATA{1'b1}};

    md_state_e            state_r;
    logic [CW-1:0]        cnt_r;
    logic                 busy_r;
    logic                 is_div_r;
    logic                 neg_q_r;
    logic                 neg_r_r;
    logic                 dz_r;
    logic [NB_DATA-1:0]   dvsr_r;
    logic [NB_DATA-1:0]   acc_hi_r;
    logic [NB_DATA-1:0]   acc_lo_r;

    logic                 is_signed_s;
    logic                 ld_is_div_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [NB_DATA-1:0]   a_mag_s;
    logic [NB_DATA-1:0]   b_mag_s;
    logic [NB_DATA-1:0]   h_s;
    logic [NB_DATA-1:0]   l_s;
    logic [NB_DATA:0]     t_s;
    logic [2*NB_DATA-1:0] prod_s;
    logic [2*NB_DATA-1:0] prod_fix_s;
    logic [NB_DATA-1:0]   q_s;
    logic [NB_DATA-1:0]   r_s;

    assign is_signed_s = (op == MD_MULT) || (op == MD_DIV);
    assign ld_is_div_s = (op == MD_DIV) || (op == MD_DIVU);
    assign a_neg_s     = is_signed_s & a[NB_DATA-1];
    assign b_neg_s     = is_signed_s & b[NB_DATA-1];
    assign a_mag_s     = a_neg_s ? (ZERO - a) : a;
    assign b_mag_s     = b_neg_s ? (ZERO - b) : b;

    // One RUN-cycle worth of shift-add (multiply) or restoring-subtract (divide) steps
    always_comb begin
        h_s = acc_hi_r;
        l_s = acc_lo_r;
        t_s = {(NB_DATA+1){1'b0}};
        for (int k = 0; k < MD_BITS_PER_CYC; k++) begin
            if (is_div_r) begin
                t_s = {h_s, l_s[NB_DATA-1]};
                l_s = {l_s[NB_DATA-2:0], 1'b0};
                if (t_s >= {1'b0, dvsr_r}) begin
                    t_s    = t_s - {1'b0, dvsr_r};
                    l_s[0] = 1'b1;
                end else begin
                    l_s[0] = 1'b0;
                end
                h_s = t_s[NB_DATA-1:0];
            end else begin
                t_s = {1'b0, h_s} + (l_s[0] ? {1'b0, dvsr_r} : {(NB_DATA+1){1'b0}});
                l_s = {t_s[0], l_s[NB_DATA-1:1]};
                h_s = t_s[NB_DATA:1];
            end
        end
    end

    // Divide-by-zero leaves the dividend magnitude in the remainder, so only LO needs forcing
    assign prod_s     = {acc_hi_r, acc_lo_r};
    assign prod_fix_s = neg_q_r ? ({(2*NB_DATA){1'b0}} - prod_s) : prod_s;
    assign q_s        = dz_r ? ONES : (neg_q_r ? (ZERO - acc_lo_r) : acc_lo_r);
    assign r_s        = neg_r_r ? (ZERO - acc_hi_r) : acc_hi_r;
    assign hi         = is_div_r ? r_s : prod_fix_s[2*NB_DATA-1:NB_DATA];
    assign lo         = is_div_r ? q_s : prod_fix_s[NB_DATA-1:0];
    assign done       = (state_r == MD_FIX);
    assign busy       = busy_r;

    // Sequencer IDLE -> RUN -> FIX -> IDLE; a new start is also taken from FIX
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= MD_IDLE;
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dz_r     <= 1'b0;
            dvsr_r   <= ZERO;
            acc_hi_r <= ZERO;
            acc_lo_r <= ZERO;
        end else begin
            case (state_r)
                MD_IDLE, MD_FIX: begin
                    if (start) begin
                        state_r  <= MD_RUN;
                        cnt_r    <= CNT_LAST;
                        busy_r   <= 1'b1;
                        is_div_r <= ld_is_div_s;
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        dz_r     <= ld_is_div_s & (b == ZERO);
                        dvsr_r   <= ld_is_div_s ? b_mag_s : a_mag_s;
                        acc_hi_r <= ZERO;
                        acc_lo_r <= ld_is_div_s ? a_mag_s : b_mag_s;
                    end else begin
                        state_r <= MD_IDLE;
                    end
                end
                MD_RUN: begin
                    acc_hi_r <= h_s;
                    acc_lo_r <= l_s;
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= MD_FIX;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= MD_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_md.sv
// MIPS-style execute stage: forwarding, single-cycle ALU, HI/LO and an
// iterative mul/div unit, feeding the EX/MEM pipeline register.
module ex_stage_md
    import mips_pkg::*;
#(
    parameter int NB_DATA         = 32,
    parameter int NB_REG          = 5,
    parameter int MD_BITS_PER_CYC = 1
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_reg_DA,
    input  logic [NB_DATA-1:0] i_reg_DB,
    input  logic [NB_DATA-1:0] i_fwd_exmem,
    input  logic [NB_DATA-1:0] i_fwd_memwb,
    input  logic [1:0]         i_fw_a,
    input  logic [1:0]         i_fw_b,
    input  logic [NB_DATA-1:0] i_immediate,
    input  logic               i_immediate_flag,
    input  logic [5:0]         i_alu_ctrl,
    input  logic [4:0]         i_shamt,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic               i_regDst,
    input  logic [CTRL_W-1:0]  i_ctrl,
    output logic [CTRL_W-1:0]  o_ctrl,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_data4Mem,
    output logic               o_md_busy
);

    localparam int SW = $clog2(NB_DATA);
    localparam logic [NB_DATA-1:0] DZERO = {NB_DATA{1'b0}};
    localparam logic [NB_REG-1:0]  RZERO = {NB_REG{1'b0}};
    localparam logic [CTRL_W-1:0]  CZERO = {CTRL_W{1'b0}};

    alu_op_e            op_s;
    logic [NB_DATA-1:0] opa_s;
    logic [NB_DATA-1:0] fwd_b_s;
    logic [NB_DATA-1:0] alu_b_s;
    logic [SW-1:0]      sh_s;
    logic [SW-1:0]      vsh_s;
    logic [NB_DATA-1:0] res_s;
    logic [NB_DATA-1:0] hi_r;
    logic [NB_DATA-1:0] lo_r;
    logic [NB_DATA-1:0] hi_s;
    logic [NB_DATA-1:0] lo_s;
    logic               acc_s;
    logic               is_md_s;
    logic               md_start_s;
    logic               mthi_s;
    logic               mtlo_s;
    logic               md_busy_s;
    logic               md_done_s;
    logic [NB_DATA-1:0] md_hi_s;
    logic [NB_DATA-1:0] md_lo_s;

    assign op_s    = alu_op_e'(i_alu_ctrl);
    assign is_md_s = is_md_op(op_s);

    // A flushed instruction is squashed, so it gets no HI/LO side effect either
    assign acc_s      = i_valid & ~i_stall & ~i_flush;
    assign md_start_s = acc_s & ~md_busy_s & is_md_s;
    assign mthi_s     = acc_s & ~md_busy_s & (op_s == ALU_MTHI);
    assign mtlo_s     = acc_s & ~md_busy_s & (op_s == ALU_MTLO);

    // Operand forwarding; the reserved select falls back to the register file
    always_comb begin
        case (i_fw_a)
            FW_MEMWB: opa_s = i_fwd_memwb;
            FW_EXMEM: opa_s = i_fwd_exmem;
            default:  opa_s = i_reg_DA;
        endcase
        case (i_fw_b)
            FW_MEMWB: fwd_b_s = i_fwd_memwb;
            FW_EXMEM: fwd_b_s = i_fwd_exmem;
            default:  fwd_b_s = i_reg_DB;
        endcase
    end

    assign alu_b_s = i_immediate_flag ? i_immediate : fwd_b_s;
    assign sh_s    = SW'(i_shamt);
    assign vsh_s   = opa_s[SW-1:0];

    // Results finishing this cycle are visible to MFHI/MFLO before HI/LO capture them
    assign hi_s = md_done_s ? md_hi_s : hi_r;
    assign lo_s = md_done_s ? md_lo_s : lo_r;

    // Single-cycle ALU; unlisted codes and HI/LO writes produce zero
    always_comb begin
        case (op_s)
            ALU_ADD, ALU_ADDU: res_s = opa_s + alu_b_s;
            ALU_SUB, ALU_SUBU: res_s = opa_s - alu_b_s;
            ALU_AND:  res_s = opa_s & alu_b_s;
            ALU_OR:   res_s = opa_s | alu_b_s;
            ALU_XOR:  res_s = opa_s ^ alu_b_s;
            ALU_NOR:  res_s = ~(opa_s | alu_b_s);
            ALU_SLT:  res_s = {{(NB_DATA-1){1'b0}}, ($signed(opa_s) < $signed(alu_b_s))};
            ALU_SLTU: res_s = {{(NB_DATA-1){1'b0}}, (opa_s < alu_b_s)};
            ALU_SLL:  res_s = alu_b_s << sh_s;
            ALU_SRL:  res_s = alu_b_s >> sh_s;
            ALU_SRA:  res_s = $signed(alu_b_s) >>> sh_s;
            ALU_SLLV: res_s = alu_b_s << vsh_s;
            ALU_SRLV: res_s = alu_b_s >> vsh_s;
            ALU_SRAV: res_s = $signed(alu_b_s) >>> vsh_s;
            ALU_LUI:  res_s = i_immediate << (NB_DATA / 2);
            ALU_MFHI: res_s = hi_s;
            ALU_MFLO: res_s = lo_s;
            default:  res_s = DZERO;
        endcase
    end

    md_unit #(
        .NB_DATA         (NB_DATA),
        .MD_BITS_PER_CYC (MD_BITS_PER_CYC)
    ) u_md (
        .clk   (clk),
        .rst_n (i_rst_n),
        .start (md_start_s),
        .op    (to_md_op(op_s)),
        .a     (opa_s),
        .b     (fwd_b_s),
        .busy  (md_busy_s),
        .done  (md_done_s),
        .hi    (md_hi_s),
        .lo    (md_lo_s)
    );

    // HI/LO: an MTHI/MTLO in the completion cycle is younger, so it wins
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            hi_r <= DZERO;
            lo_r <= DZERO;
        end else begin
            hi_r <= mthi_s ? opa_s : (md_done_s ? md_hi_s : hi_r);
            lo_r <= mtlo_s ? opa_s : (md_done_s ? md_lo_s : lo_r);
        end
    end

    // EX/MEM register: flush beats stall; mul/div issue and empty slots become bubbles
    always_ff @(posedge clk) begin
        if (!i_rst_n || i_flush) begin
            o_ctrl      <= CZERO;
            o_write_reg <= RZERO;
            o_result    <= DZERO;
            o_data4Mem  <= DZERO;
        end else if (i_stall) begin
            o_ctrl      <= o_ctrl;
            o_write_reg <= o_write_reg;
            o_result    <= o_result;
            o_data4Mem  <= o_data4Mem;
        end else if (i_valid && !is_md_s) begin
            o_ctrl      <= i_ctrl;
            o_write_reg <= i_regDst ? i_rd : i_rt;
            o_result    <= res_s;
            o_data4Mem  <= fwd_b_s;
        end else begin
            o_ctrl      <= CZERO;
            o_write_reg <= RZERO;
            o_result    <= DZERO;
            o_data4Mem  <= DZERO;
        end
    end

    assign o_md_busy = md_busy_s;

endmodule
